// File: rtl/playback_buffer_if.sv
// Controller <-> playback buffer bus: entry push, playback pacing and display outputs.
// The overflow signal exists only when BUF_OVERFLOW_EN is defined.
interface playback_buffer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) ();
    logic                     clear;
    logic [WIDTH-1:0]         din;
    logic                     write_enable;
    logic                     read_enable;
    logic                     timer_enable;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   level;
    logic                     timer;
    logic [WIDTH-1:0]         display_data;
    logic                     display_valid;
`ifdef BUF_OVERFLOW_EN
    logic                     overflow;

    modport master (
        output clear, din, write_enable, read_enable, timer_enable,
        input  empty, full, level, timer, display_data, display_valid, overflow
    );
    modport slave (
        input  clear, din, write_enable, read_enable, timer_enable,
        output empty, full, level, timer, display_data, display_valid, overflow
    );
`else
    modport master (
        output clear, din, write_enable, read_enable, timer_enable,
        input  empty, full, level, timer, display_data, display_valid
    );
    modport slave (
        input  clear, din, write_enable, read_enable, timer_enable,
        output empty, full, level, timer, display_data, display_valid
    );
`endif
endinterface

// File: rtl/playback_buffer.sv
// Entry FIFO with dwell-paced playback into a display register.
// Define BUF_OVERFLOW_EN to add the sticky overflow flag for dropped pushes.
module playback_buffer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DWELL = 50000000
) (
    input logic              clk,
    input logic              reset_n,
    playback_buffer_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned CntW = $clog2(DWELL);
    localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);
    localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [LvlW-1:0]  level_q;
    logic [LvlW-1:0]  level_d;
    logic             empty_q;
    logic             full_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] display_data_q;
    logic             display_valid_q;
    logic             timer_pulse;
    logic             push;
    logic             pop;

    // Status flags are registered, so a push at full or pop at empty is judged on last edge's view
    assign timer_pulse = bus.timer_enable && (cnt_q == CntLast);
    assign push        = bus.write_enable && !full_q && !bus.clear;
    assign pop         = bus.read_enable && timer_pulse && !empty_q && !bus.clear;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            empty_q         <= 1'b1;
            full_q          <= 1'b0;
            display_data_q  <= '0;
            display_valid_q <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            empty_q         <= 1'b1;
            full_q          <= 1'b0;
            display_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q        <= rd_ptr_q + PtrW'(1);
                display_data_q  <= mem_q[rd_ptr_q];
                display_valid_q <= 1'b1;
            end
            level_q <= level_d;
            empty_q <= (level_d == '0);
            full_q  <= (level_d == LvlFull);
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are meaningful
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (bus.clear || !bus.timer_enable) begin
            cnt_q <= '0;
        end else if (cnt_q == CntLast) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

`ifdef BUF_OVERFLOW_EN
    logic overflow_q;

    // Clear takes precedence, so a write during clear leaves the flag low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (bus.clear) begin
            overflow_q <= 1'b0;
        end else if (bus.write_enable && full_q) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.overflow = overflow_q;
`endif

    assign bus.empty         = empty_q;
    assign bus.full          = full_q;
    assign bus.level         = level_q;
    assign bus.timer         = timer_pulse;
    assign bus.display_data  = display_data_q;
    assign bus.display_valid = display_valid_q;
endmodule
